// File: rtl/risc_toy_ifetch.sv
// rtl/risc_toy_ifetch.sv - prefetching instruction-fetch unit for the RISC_TOY core family
//
// Purpose: owns the PC, issues in-order requests on a request/grant/response
// instruction-memory port, and buffers up to DEPTH fetches in a circular buffer.
// The oldest fetch is presented to decode as {OUT_INSTR, OUT_PC} over a
// valid/ready handshake. REDIR flushes the buffer and discards in-flight fetches.
//
// Optional feature: define IFETCH_PERF_EN to add PERF_FETCHED / PERF_BUBBLE /
// PERF_REDIR 32-bit event counters.
//
// Ports:
//   CLK, RSTN            clock, asynchronous active-low reset
//   IREQ, IADDR, IGNT    fetch request, word address (= PC), memory grant
//   IVALID, INSTR        in-order fetch response
//   REDIR, REDIR_ADDR    redirect strobe and target word address
//   OUT_VALID/INSTR/PC   head instruction towards decode
//   OUT_READY            decode accepts head
//   PERF_*               event counters (IFETCH_PERF_EN only)
module risc_toy_ifetch #(
  parameter int              AW     = 30,
  parameter int              IW     = 32,
  parameter int              DEPTH  = 4,
  parameter logic [AW-1:0]   RST_PC = '0
) (
  input  logic          CLK,
  input  logic          RSTN,
  output logic          IREQ,
  output logic [AW-1:0] IADDR,
  input  logic          IGNT,
  input  logic          IVALID,
  input  logic [IW-1:0] INSTR,
  input  logic          REDIR,
  input  logic [AW-1:0] REDIR_ADDR,
  output logic          OUT_VALID,
  output logic [IW-1:0] OUT_INSTR,
  output logic [AW-1:0] OUT_PC,
  input  logic          OUT_READY
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]   PERF_FETCHED,
  output logic [31:0]   PERF_BUBBLE,
  output logic [31:0]   PERF_REDIR
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Drop counter is wider than the occupancy counter because back-to-back
  // redirects against a slow memory accumulate outstanding discards.
  localparam int DW = CW + 4;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic          run_q, run_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [DW-1:0] drop_q, drop_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [AW-1:0] spc_q   [DEPTH];
  logic [AW-1:0] spc_d   [DEPTH];
  logic [IW-1:0] sinstr_q[DEPTH];
  logic [IW-1:0] sinstr_d[DEPTH];

  logic          ireq, issue, resp, discard, out_valid, pop;
  logic [PW-1:0] fill_idx;

  // Reserved-but-unfilled slots are always the youngest in-flight ones, so the
  // oldest of them sits inflight_q entries behind the tail.
  assign fill_idx  = tail_q - inflight_q[PW-1:0];
  assign ireq      = run_q & ~REDIR & (count_q < FULL);
  assign issue     = ireq & IGNT;
  assign resp      = IVALID & (drop_q == '0) & (inflight_q != '0);
  assign discard   = IVALID & (drop_q != '0);
  assign out_valid = filled_q[head_q] & ~REDIR;
  assign pop       = out_valid & OUT_READY;

  assign IREQ      = ireq;
  assign IADDR     = pc_q;
  assign OUT_VALID = out_valid;
  assign OUT_INSTR = sinstr_q[head_q];
  assign OUT_PC    = spc_q[head_q];

  always_comb begin
    run_d      = 1'b1;
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    filled_d   = filled_q;
    spc_d      = spc_q;
    sinstr_d   = sinstr_q;
    if (REDIR) begin
      // Everything still owed by memory becomes a discard, except a response
      // landing this very cycle, which is consumed here.
      pc_d       = REDIR_ADDR;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      inflight_d = '0;
      filled_d   = '0;
      drop_d     = drop_q - DW'(discard) + DW'(inflight_q) - DW'(resp);
    end else begin
      if (pop) filled_d[head_q] = 1'b0;
      if (issue) begin
        spc_d[tail_q]    = pc_q;
        filled_d[tail_q] = 1'b0;
        pc_d             = pc_q + AW'(1);
      end
      if (resp) begin
        sinstr_d[fill_idx] = INSTR;
        filled_d[fill_idx] = 1'b1;
      end
      head_d     = head_q + PW'(pop);
      tail_d     = tail_q + PW'(issue);
      count_d    = count_q + CW'(issue) - CW'(pop);
      inflight_d = inflight_q + CW'(issue) - CW'(resp);
      drop_d     = drop_q - DW'(discard);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      run_q      <= 1'b0;
      pc_q       <= RST_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      filled_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        spc_q[i]    <= '0;
        sinstr_q[i] <= '0;
      end
    end else begin
      run_q      <= run_d;
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      filled_q   <= filled_d;
      spc_q      <= spc_d;
      sinstr_q   <= sinstr_d;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d, bubble_q, bubble_d, redir_q, redir_d;

  always_comb begin
    fetched_d = fetched_q + 32'(pop);
    bubble_d  = bubble_q + 32'(OUT_READY & ~out_valid);
    redir_d   = redir_q + 32'(REDIR);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      fetched_q <= '0;
      bubble_q  <= '0;
      redir_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      bubble_q  <= bubble_d;
      redir_q   <= redir_d;
    end
  end

  assign PERF_FETCHED = fetched_q;
  assign PERF_BUBBLE  = bubble_q;
  assign PERF_REDIR   = redir_q;
`endif

endmodule
